// File: rtl/enemy_fleet_ctrl.sv
// Fleet march controller: paces the shared enemy step strobe, picks the march
// direction with a one-step look-ahead at the screen edges, and halts on win/loss.
module enemy_fleet_ctrl #(
   parameter int LEFT_BOUND  = 16,
   parameter int RIGHT_BOUND = 623,
   parameter int STEP_X      = 4,
   parameter int INVADE_Y    = 400,
   parameter int MIN_PERIOD  = 2,
   parameter int SPEED_SHIFT = 2
) (
   input  logic       frame_clk,
   input  logic       Reset,
   input  logic       start,
   input  logic [5:0] alive_count,
   input  logic [9:0] fleet_min_x,
   input  logic [9:0] fleet_max_x,
   input  logic [9:0] fleet_max_y,
   output logic       enemy_move,
   output logic       enemy_direction_X,
   output logic       enemy_direction_Y,
   output logic       fleet_invaded,
   output logic       fleet_cleared
);

   typedef enum logic [1:0] {IDLE, MARCH, HALT} state_t;

   localparam logic [10:0] RIGHT_LIM = 11'(RIGHT_BOUND);
   localparam logic [10:0] LEFT_LIM  = 11'(LEFT_BOUND + STEP_X);
   localparam logic [10:0] INV_LIM   = 11'(INVADE_Y);
   localparam logic [10:0] STEP11    = 11'(STEP_X);

   state_t     state_q;
   logic [7:0] cnt_q, cnt_d;
   logic       move_q, dirx_q, diry_q, inv_q, clr_q;

   logic [7:0] period;
   logic       term, turn_r, turn_l, invaded;

   assign period  = 8'(MIN_PERIOD) + ({2'b00, alive_count} >> SPEED_SHIFT);
   // >= rather than == so a shrinking period never strands the counter;
   // the move_q gate keeps strobes apart even when period is 1.
   assign term    = (cnt_q >= (period - 8'd1)) && !move_q;
   assign cnt_d   = cnt_q + 8'd1;
   assign turn_r  = dirx_q && (({1'b0, fleet_max_x} + STEP11) > RIGHT_LIM);
   assign turn_l  = !dirx_q && ({1'b0, fleet_min_x} < LEFT_LIM);
   assign invaded = {1'b0, fleet_max_y} >= INV_LIM;

   always_ff @(posedge frame_clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         move_q  <= 1'b0;
         dirx_q  <= 1'b0;
         diry_q  <= 1'b0;
         inv_q   <= 1'b0;
         clr_q   <= 1'b0;
      end else begin
         move_q <= 1'b0;
         diry_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= MARCH;
                  cnt_q   <= 8'd0;
                  dirx_q  <= 1'b0;
               end
            end
            MARCH: begin
               if (alive_count == 6'd0) begin
                  state_q <= HALT;
                  clr_q   <= 1'b1;
               end else if (invaded) begin
                  state_q <= HALT;
                  inv_q   <= 1'b1;
               end else if (term) begin
                  cnt_q  <= 8'd0;
                  move_q <= 1'b1;
                  // Turn and descend on the same strobe: a diagonal inward step.
                  if (turn_r) begin
                     dirx_q <= 1'b0;
                     diry_q <= 1'b1;
                  end else if (turn_l) begin
                     dirx_q <= 1'b1;
                     diry_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: ;
         endcase
      end
   end

   assign enemy_move        = move_q;
   assign enemy_direction_X = dirx_q;
   assign enemy_direction_Y = diry_q;
   assign fleet_invaded     = inv_q;
   assign fleet_cleared     = clr_q;

endmodule

// File: tb/tb_enemy_fleet_ctrl.sv
// Bench for enemy_fleet_ctrl: a frame-time reference model predicts strobes and
// flags; a monitor compares every frame against those predictions.
module tb_enemy_fleet_ctrl;

   localparam int LB = 16, RB = 623, SX = 4, IY = 400, MP = 2, SS = 2;

   logic       frame_clk, Reset, start;
   logic [5:0] alive_count;
   logic [9:0] fleet_min_x, fleet_max_x, fleet_max_y;
   logic       enemy_move, enemy_direction_X, enemy_direction_Y;
   logic       fleet_invaded, fleet_cleared;

   enemy_fleet_ctrl #(
      .LEFT_BOUND(LB), .RIGHT_BOUND(RB), .STEP_X(SX),
      .INVADE_Y(IY), .MIN_PERIOD(MP), .SPEED_SHIFT(SS)
   ) dut (
      .frame_clk(frame_clk), .Reset(Reset), .start(start),
      .alive_count(alive_count), .fleet_min_x(fleet_min_x),
      .fleet_max_x(fleet_max_x), .fleet_max_y(fleet_max_y),
      .enemy_move(enemy_move), .enemy_direction_X(enemy_direction_X),
      .enemy_direction_Y(enemy_direction_Y),
      .fleet_invaded(fleet_invaded), .fleet_cleared(fleet_cleared)
   );

   initial frame_clk = 1'b0;
   always #5 frame_clk = ~frame_clk;

   typedef struct {int f; logic dy;} stb_t;
   stb_t       sq[$];            // expected strobes, frame-stamped
   logic [2:0] exp_t[int];       // per frame: {dir_x, invaded, cleared}

   int  n_chk = 0, n_fail = 0;
   int  frame = 0;

   // reference model state: frame-time bookkeeping only
   int   mode = 0;               // 0 waiting, 1 marching, 2 finished
   int   last_evt = 0, last_stb = -10;
   logic mdirx = 0, minv = 0, mclr = 0;
   bit   strobe_pred;

   task automatic chk(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s frame %0d: got %b want %b", name, frame, act, exp);
      end
   endtask

   // Drive inputs for the next frame edge and predict what that edge produces.
   task automatic step(input bit rst, input bit st, input int al, input int mnx,
                       input int mxx, input int mxy);
      int e, p;
      logic dy;
      @(negedge frame_clk);
      Reset = !rst; start = st; alive_count = 6'(al);
      fleet_min_x = 10'(mnx); fleet_max_x = 10'(mxx); fleet_max_y = 10'(mxy);
      e = frame + 1;
      strobe_pred = 0;
      if (rst) begin
         mode = 0; mdirx = 0; minv = 0; mclr = 0; last_stb = -10;
      end else if (mode == 0) begin
         if (st) begin mode = 1; last_evt = e; mdirx = 0; end
      end else if (mode == 1) begin
         if (al == 0) begin mode = 2; mclr = 1; end
         else if (mxy >= IY) begin mode = 2; minv = 1; end
         else begin
            p = MP + al / (1 << SS);
            if (e - last_evt >= p && last_stb != e - 1) begin
               dy = 0;
               if (mdirx && mxx + SX > RB) begin mdirx = 0; dy = 1; end
               else if (!mdirx && mnx < LB + SX) begin mdirx = 1; dy = 1; end
               sq.push_back('{f: e, dy: dy});
               last_evt = e; last_stb = e; strobe_pred = 1;
            end
         end
      end
      exp_t[e] = {mdirx, minv, mclr};
   endtask

   task automatic run(input int n, input int al, input int mnx, input int mxx, input int mxy);
      for (int i = 0; i < n; i++) step(0, 0, al, mnx, mxx, mxy);
   endtask

   task automatic wait_strobe(input int al, input int mnx, input int mxx, input int mxy);
      for (int i = 0; i < 100; i++) begin
         step(0, 0, al, mnx, mxx, mxy);
         if (strobe_pred) return;
      end
      n_chk++; n_fail++;
      $display("FAIL wait_strobe: no strobe predicted within 100 frames, want one");
   endtask

   // Monitor: compares flags/direction every frame, strobes against the queue.
   always @(posedge frame_clk) begin
      stb_t s;
      frame = frame + 1;
      #1;
      if (exp_t.exists(frame)) begin
         chk("dir_x", enemy_direction_X, exp_t[frame][2]);
         chk("invaded", fleet_invaded, exp_t[frame][1]);
         chk("cleared", fleet_cleared, exp_t[frame][0]);
         if (enemy_move) begin
            if (sq.size() == 0 || sq[0].f != frame) begin
               n_chk++; n_fail++;
               $display("FAIL unexpected_strobe frame %0d: got move=1 want 0", frame);
            end else begin
               s = sq.pop_front();
               chk("strobe_dir_y", enemy_direction_Y, s.dy);
            end
         end else begin
            chk("idle_dir_y", enemy_direction_Y, 1'b0);
            if (sq.size() != 0 && sq[0].f <= frame) begin
               n_chk++; n_fail++;
               $display("FAIL missed_strobe frame %0d: got move=0 want 1", sq[0].f);
               void'(sq.pop_front());
            end
         end
      end
   end

   initial begin
      Reset = 1'b0; start = 1'b0; alive_count = '0;
      fleet_min_x = '0; fleet_max_x = '0; fleet_max_y = '0;
      #1;
      chk("reset_move", enemy_move, 1'b0);
      chk("reset_inv", fleet_invaded, 1'b0);
      chk("reset_clr", fleet_cleared, 1'b0);
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0);

      // Nominal march: period 12, no turns
      step(0, 1, 40, 300, 500, 100);
      run(40, 40, 300, 500, 100);

      // Left edge turn, then the next strobe is a plain step right
      run(30, 40, 19, 500, 100);

      // Right edge: 619 holds course, 620 turns
      run(15, 40, 300, 619, 100);
      run(15, 40, 300, 620, 100);
      run(10, 40, 300, 500, 100);

      // Speed-up with the counter at 9
      wait_strobe(40, 300, 500, 100);
      run(9, 40, 300, 500, 100);
      run(12, 4, 300, 500, 100);

      // Randomized marching
      for (int i = 0; i < 300; i++)
         step(0, $urandom_range(3, 0) == 0, $urandom_range(55, 1),
              $urandom_range(1, 0) ? $urandom_range(30, 0) : $urandom_range(330, 280),
              $urandom_range(630, 590), $urandom_range(399, 50));

      // Asynchronous reset while a strobe is up
      wait_strobe(40, 300, 500, 100);
      @(posedge frame_clk); #2;
      chk("pre_rst_move", enemy_move, 1'b1);
      #1 Reset = 1'b0;
      #1;
      chk("async_move", enemy_move, 1'b0);
      chk("async_dir_y", enemy_direction_Y, 1'b0);
      chk("async_dir_x", enemy_direction_X, 1'b0);
      step(1, 0, 40, 300, 500, 100);
      run(20, 40, 300, 500, 100);

      // Invasion, later start ignored
      step(0, 1, 40, 300, 500, 100);
      run(15, 40, 300, 500, 100);
      run(3, 40, 300, 500, 400);
      for (int i = 0; i < 3; i++) step(0, 1, 40, 300, 500, 100);
      run(20, 40, 300, 500, 100);
      #2;
      chk("halt_inv", fleet_invaded, 1'b1);
      chk("halt_move", enemy_move, 1'b0);

      // Both halt conditions at once: cleared wins
      step(1, 0, 40, 300, 500, 100);
      step(0, 1, 40, 300, 500, 100);
      run(5, 40, 300, 500, 100);
      run(3, 0, 300, 500, 400);
      run(5, 40, 300, 500, 100);
      #2;
      chk("both_clr", fleet_cleared, 1'b1);
      chk("both_inv", fleet_invaded, 1'b0);

      repeat (3) @(posedge frame_clk);
      #2;
      n_chk++;
      if (sq.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending strobes want 0", sq.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
